// File: rtl/audio_voice_scheduler.sv
// audio_voice_scheduler
//   Places sound-effect requests from game logic onto the four PWM channels
//   of the audio output stage. Each voice has a level (pulsewidth), a
//   priority and a duration counted in prescaled ticks. When every channel
//   is busy, a request may preempt a strictly lower-priority voice.
//   Otherwise the request is dropped.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid / req_ready       request handshake (one request per 2 cycles)
//   req_level, req_prio,        pulsewidth, priority (3 highest) and
//   req_dur                     duration in ticks of the requested voice
//   stop_all                    synchronous silence-all
//   pulsewidth0..pulsewidth3    per-channel pulsewidth to the mixer
//   chan_busy                   bit n high while channel n holds a voice
//   drop_pulse                  one-cycle pulse per discarded request
//   mute                        high when no channel is busy
module audio_voice_scheduler #(
    parameter int BITRES   = 8,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BITRES-1:0] req_level,
    input  logic [1:0]        req_prio,
    input  logic [DUR_W-1:0]  req_dur,
    input  logic              stop_all,
    output logic [BITRES-1:0] pulsewidth0,
    output logic [BITRES-1:0] pulsewidth1,
    output logic [BITRES-1:0] pulsewidth2,
    output logic [BITRES-1:0] pulsewidth3,
    output logic [3:0]        chan_busy,
    output logic              drop_pulse,
    output logic              mute
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ALLOC = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               drop_q, drop_d;
    logic               mute_q, mute_d;
    logic [3:0]         busy_q, busy_d;
    logic [BITRES-1:0]  pw_q   [4];
    logic [BITRES-1:0]  pw_d   [4];
    logic [DUR_W-1:0]   rem_q  [4];
    logic [DUR_W-1:0]   rem_d  [4];
    logic [1:0]         prio_q [4];
    logic [1:0]         prio_d [4];
    logic [BITRES-1:0]  lvl_q, lvl_d;
    logic [1:0]         cprio_q, cprio_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [PRE_W-1:0]   presc_q, presc_d;

    logic               tick;
    logic               accept;
    logic               have_target;
    logic [1:0]         target;

    // Free-running prescaler; independent of requests and stop_all.
    assign tick    = (presc_q == PRE_W'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PRE_W'(1);

    assign accept = (state_q == S_IDLE) && req_valid && ready_q;

    // Target selection works on pre-edge occupancy: a channel freed by a tick
    // on the ALLOC edge is not yet free. Lowest free channel first; otherwise
    // the lowest-priority voice strictly below the request (lowest index on
    // ties, because only a strictly smaller priority replaces the candidate).
    always_comb begin
        logic       found_free;
        logic [1:0] best_prio;
        found_free  = 1'b0;
        have_target = 1'b0;
        target      = 2'd0;
        best_prio   = cprio_q;
        for (int i = 3; i >= 0; i--) begin
            if (!busy_q[i]) begin
                found_free = 1'b1;
                target     = 2'(i);
            end
        end
        if (found_free) begin
            have_target = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (prio_q[i] < best_prio) begin
                    best_prio   = prio_q[i];
                    target      = 2'(i);
                    have_target = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        drop_d  = 1'b0;
        lvl_d   = lvl_q;
        cprio_d = cprio_q;
        dur_d   = dur_q;
        busy_d  = busy_q;
        pw_d    = pw_q;
        rem_d   = rem_q;
        prio_d  = prio_q;

        // Duration ageing; a voice on its last tick frees the channel.
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                if (busy_q[i]) begin
                    if (rem_q[i] > DUR_W'(1)) begin
                        rem_d[i] = rem_q[i] - DUR_W'(1);
                    end else begin
                        busy_d[i] = 1'b0;
                        pw_d[i]   = '0;
                        rem_d[i]  = '0;
                        prio_d[i] = '0;
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lvl_d   = req_level;
                    cprio_d = req_prio;
                    dur_d   = req_dur;
                    state_d = S_ALLOC;
                    ready_d = 1'b0;
                end else begin
                    ready_d = ~stop_all;
                end
            end
            S_ALLOC: begin
                state_d = S_IDLE;
                ready_d = ~stop_all;
                if (!stop_all) begin
                    if (dur_q == '0 || !have_target) begin
                        drop_d = 1'b1;
                    end else begin
                        // The write overrides any same-edge tick on this channel.
                        busy_d[target] = 1'b1;
                        pw_d[target]   = lvl_q;
                        rem_d[target]  = dur_q;
                        prio_d[target] = cprio_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop_all) begin
            busy_d = '0;
            for (int i = 0; i < 4; i++) begin
                pw_d[i]   = '0;
                rem_d[i]  = '0;
                prio_d[i] = '0;
            end
        end
    end

    assign mute_d = ~|busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
            mute_q  <= 1'b1;
            busy_q  <= '0;
            lvl_q   <= '0;
            cprio_q <= '0;
            dur_q   <= '0;
            presc_q <= '0;
            for (int i = 0; i < 4; i++) begin
                pw_q[i]   <= '0;
                rem_q[i]  <= '0;
                prio_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
            mute_q  <= mute_d;
            busy_q  <= busy_d;
            lvl_q   <= lvl_d;
            cprio_q <= cprio_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            for (int i = 0; i < 4; i++) begin
                pw_q[i]   <= pw_d[i];
                rem_q[i]  <= rem_d[i];
                prio_q[i] <= prio_d[i];
            end
        end
    end

    assign req_ready   = ready_q;
    assign drop_pulse  = drop_q;
    assign mute        = mute_q;
    assign chan_busy   = busy_q;
    assign pulsewidth0 = pw_q[0];
    assign pulsewidth1 = pw_q[1];
    assign pulsewidth2 = pw_q[2];
    assign pulsewidth3 = pw_q[3];

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Directed bench for audio_voice_scheduler with TICK_DIV = 4.
// Edges are counted from reset release (ecnt); the prescaler ticks on every
// edge whose count is a multiple of 4.
module tb_audio_voice_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_level;
    logic [1:0] req_prio;
    logic [7:0] req_dur;
    logic       stop_all;
    logic [7:0] pulsewidth0, pulsewidth1, pulsewidth2, pulsewidth3;
    logic [3:0] chan_busy;
    logic       drop_pulse;
    logic       mute;
    logic [31:0] pw_all;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    assign pw_all = {pulsewidth3, pulsewidth2, pulsewidth1, pulsewidth0};

    audio_voice_scheduler #(.BITRES(8), .DUR_W(8), .TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_level  (req_level),
        .req_prio   (req_prio),
        .req_dur    (req_dur),
        .stop_all   (stop_all),
        .pulsewidth0(pulsewidth0),
        .pulsewidth1(pulsewidth1),
        .pulsewidth2(pulsewidth2),
        .pulsewidth3(pulsewidth3),
        .chan_busy  (chan_busy),
        .drop_pulse (drop_pulse),
        .mute       (mute)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic step_to(input int target);
        while (ecnt < target) step();
    endtask

    // Request handshake: accepting edge, then ALLOC edge.
    task automatic send(input logic [7:0] lvl, input logic [1:0] p, input logic [7:0] d);
        req_level = lvl;
        req_prio  = p;
        req_dur   = d;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; stop_all = 1'b0;
        req_level = '0; req_prio = '0; req_dur = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pw_all !== 32'h0) begin failures++; $display("FAIL reset_pw got=%h exp=%h", pw_all, 32'h0); end
        checks++; if (chan_busy !== 4'b0000) begin failures++; $display("FAIL reset_busy got=%b exp=0000", chan_busy); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL reset_mute got=%b exp=1", mute); end
        checks++; if (drop_pulse !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop_pulse); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        reset = 1'b0;
        ecnt  = 0;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
    endtask

    task automatic test_single_voice();
        send(8'h80, 2'd1, 8'd3);   // ALLOC edge 3; ticks at 4, 8, 12
        checks++; if (pulsewidth0 !== 8'h80) begin failures++; $display("FAIL single_pw0 got=%h exp=80", pulsewidth0); end
        checks++; if (chan_busy !== 4'b0001) begin failures++; $display("FAIL single_busy got=%b exp=0001", chan_busy); end
        checks++; if (mute !== 1'b0) begin failures++; $display("FAIL single_mute got=%b exp=0", mute); end
        checks++; if (drop_pulse !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", drop_pulse); end
        step_to(11);
        checks++; if (chan_busy !== 4'b0001) begin failures++; $display("FAIL single_before_end got=%b exp=0001", chan_busy); end
        step_to(12);
        checks++; if (chan_busy !== 4'b0000) begin failures++; $display("FAIL single_end_busy got=%b exp=0000", chan_busy); end
        checks++; if (pulsewidth0 !== 8'h00) begin failures++; $display("FAIL single_end_pw0 got=%h exp=00", pulsewidth0); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL single_end_mute got=%b exp=1", mute); end
    endtask

    task automatic test_fill_preempt();
        send(8'hA0, 2'd2, 8'd50);
        send(8'hA1, 2'd0, 8'd50);
        send(8'hA2, 2'd1, 8'd50);
        send(8'hA3, 2'd0, 8'd50);
        checks++; if (chan_busy !== 4'b1111) begin failures++; $display("FAIL fill_busy got=%b exp=1111", chan_busy); end
        checks++; if (pw_all !== 32'hA3A2A1A0) begin failures++; $display("FAIL fill_pw got=%h exp=A3A2A1A0", pw_all); end
        send(8'h11, 2'd3, 8'd50);   // prios 2,0,1,0 -> channel 1
        checks++; if (pw_all !== 32'hA3A211A0) begin failures++; $display("FAIL preempt1_pw got=%h exp=A3A211A0", pw_all); end
        checks++; if (drop_pulse !== 1'b0) begin failures++; $display("FAIL preempt1_drop got=%b exp=0", drop_pulse); end
        send(8'h22, 2'd3, 8'd50);   // prios 2,3,1,0 -> channel 3
        checks++; if (pw_all !== 32'h22A211A0) begin failures++; $display("FAIL preempt2_pw got=%h exp=22A211A0", pw_all); end
        send(8'h33, 2'd3, 8'd50);   // prios 2,3,1,3 -> channel 2
        checks++; if (pw_all !== 32'h223311A0) begin failures++; $display("FAIL preempt3_pw got=%h exp=223311A0", pw_all); end
        send(8'h44, 2'd3, 8'd50);   // prios 2,3,3,3 -> channel 0
        checks++; if (pw_all !== 32'h22331144) begin failures++; $display("FAIL preempt4_pw got=%h exp=22331144", pw_all); end
    endtask

    task automatic test_drop();
        send(8'h55, 2'd3, 8'd50);   // all at prio 3: no strictly lower victim
        checks++; if (drop_pulse !== 1'b1) begin failures++; $display("FAIL drop_full got=%b exp=1", drop_pulse); end
        checks++; if (pw_all !== 32'h22331144) begin failures++; $display("FAIL drop_full_pw got=%h exp=22331144", pw_all); end
        checks++; if (chan_busy !== 4'b1111) begin failures++; $display("FAIL drop_full_busy got=%b exp=1111", chan_busy); end
        step();
        checks++; if (drop_pulse !== 1'b0) begin failures++; $display("FAIL drop_width got=%b exp=0", drop_pulse); end
        send(8'h66, 2'd3, 8'd0);
        checks++; if (drop_pulse !== 1'b1) begin failures++; $display("FAIL drop_dur0_full got=%b exp=1", drop_pulse); end
        checks++; if (pw_all !== 32'h22331144) begin failures++; $display("FAIL drop_dur0_pw got=%h exp=22331144", pw_all); end
        step();
    endtask

    task automatic test_stop_all();
        req_level = 8'h77; req_prio = 2'd3; req_dur = 8'd9;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        stop_all  = 1'b1;
        step();
        checks++; if (pw_all !== 32'h0) begin failures++; $display("FAIL stop_pw got=%h exp=00000000", pw_all); end
        checks++; if (chan_busy !== 4'b0000) begin failures++; $display("FAIL stop_busy got=%b exp=0000", chan_busy); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL stop_mute got=%b exp=1", mute); end
        checks++; if (drop_pulse !== 1'b0) begin failures++; $display("FAIL stop_drop got=%b exp=0", drop_pulse); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL stop_ready_a got=%b exp=0", req_ready); end
        step();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL stop_ready_b got=%b exp=0", req_ready); end
        stop_all = 1'b0;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL stop_ready_c got=%b exp=1", req_ready); end
        checks++; if (chan_busy !== 4'b0000) begin failures++; $display("FAIL stop_after_busy got=%b exp=0000", chan_busy); end
        send(8'h5A, 2'd2, 8'd0);    // free channels, but dur 0
        checks++; if (drop_pulse !== 1'b1) begin failures++; $display("FAIL drop_dur0_free got=%b exp=1", drop_pulse); end
        checks++; if (chan_busy !== 4'b0000) begin failures++; $display("FAIL drop_dur0_free_busy got=%b exp=0000", chan_busy); end
        step();
    endtask

    task automatic test_collision();
        int ld, t2;
        send(8'h00, 2'd2, 8'd50);   // level 0 still occupies the channel
        checks++; if (chan_busy !== 4'b0001) begin failures++; $display("FAIL level0_busy got=%b exp=0001", chan_busy); end
        checks++; if (mute !== 1'b0) begin failures++; $display("FAIL level0_mute got=%b exp=0", mute); end
        send(8'hB1, 2'd2, 8'd50);
        send(8'hB2, 2'd0, 8'd2);
        ld = ecnt;
        t2 = (ld / 4 + 2) * 4;       // second tick after the load: rem2 = 1 there
        send(8'hB3, 2'd2, 8'd50);
        step_to(t2 - 2);
        checks++; if (chan_busy !== 4'b1111) begin failures++; $display("FAIL coll_pre_busy got=%b exp=1111", chan_busy); end
        send(8'h77, 2'd1, 8'd5);    // ALLOC edge lands on tick t2, victim channel 2
        checks++; if (pw_all !== 32'hB377B100) begin failures++; $display("FAIL coll_pw got=%h exp=B377B100", pw_all); end
        checks++; if (chan_busy !== 4'b1111) begin failures++; $display("FAIL coll_busy got=%b exp=1111", chan_busy); end
        checks++; if (drop_pulse !== 1'b0) begin failures++; $display("FAIL coll_drop got=%b exp=0", drop_pulse); end
        step_to(t2 + 19);           // full dur 5: clears on the 5th tick, t2+20
        checks++; if (chan_busy[2] !== 1'b1) begin failures++; $display("FAIL coll_hold got=%b exp=1", chan_busy[2]); end
        step_to(t2 + 20);
        checks++; if (chan_busy !== 4'b1011) begin failures++; $display("FAIL coll_end_busy got=%b exp=1011", chan_busy); end
        checks++; if (pulsewidth2 !== 8'h00) begin failures++; $display("FAIL coll_end_pw2 got=%h exp=00", pulsewidth2); end
    endtask

    task automatic test_async_reset();
        #2;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL areset_pre_ready got=%b exp=1", req_ready); end
        reset = 1'b1;
        #1;
        checks++; if (pw_all !== 32'h0) begin failures++; $display("FAIL areset_pw got=%h exp=00000000", pw_all); end
        checks++; if (chan_busy !== 4'b0000) begin failures++; $display("FAIL areset_busy got=%b exp=0000", chan_busy); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL areset_mute got=%b exp=1", mute); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL areset_ready got=%b exp=0", req_ready); end
        checks++; if (drop_pulse !== 1'b0) begin failures++; $display("FAIL areset_drop got=%b exp=0", drop_pulse); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        ecnt  = 0;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL areset_release_ready got=%b exp=1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_fill_preempt();
        test_drop();
        test_stop_all();
        test_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
